// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencer gating a centisecond prescaler and a
// centi/sec/min wrap-around cascade, with lap capture and a one-cycle wrap pulse.
module stopwatch_ctrl #(
  parameter int CLK_DIV     = 100,
  parameter int CENTI_LIMIT = 99,
  parameter int SEC_LIMIT   = 59,
  parameter int MIN_LIMIT   = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic       running,
  output logic [6:0] centi,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       lap_valid,
  output logic [6:0] lap_centi,
  output logic [5:0] lap_sec,
  output logic [5:0] lap_min,
  output logic       overflow
);

  localparam int             PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  DIV_LAST = PW'(CLK_DIV - 1);
  localparam logic [6:0]     C_LIM    = 7'(CENTI_LIMIT);
  localparam logic [5:0]     S_LIM    = 6'(SEC_LIMIT);
  localparam logic [5:0]     M_LIM    = 6'(MIN_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_running;
  logic [PW-1:0] r_presc;
  logic [6:0]    r_centi;
  logic [5:0]    r_sec;
  logic [5:0]    r_min;
  logic          r_overflow;
  logic          r_lap_valid;
  logic [6:0]    r_lap_centi;
  logic [5:0]    r_lap_sec;
  logic [5:0]    r_lap_min;

  logic w_in_run;
  logic w_clear_ok;
  logic w_toggle;
  logic w_lap_take;
  logic w_tick;
  logic w_centi_wrap;
  logic w_sec_wrap;
  logic w_min_wrap;

  function automatic logic [6:0] wrap_inc7(input logic [6:0] v, input logic [6:0] lim);
    if (v == lim) return 7'd0;
    else          return v + 7'd1;
  endfunction

  function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] lim);
    if (v == lim) return 6'd0;
    else          return v + 6'd1;
  endfunction

  // clear outranks start_stop outranks lap; clear in RUN still swallows the others
  assign w_in_run     = (r_state == ST_RUN);
  assign w_clear_ok   = clear && !w_in_run;
  assign w_toggle     = start_stop && !clear;
  assign w_lap_take   = lap && !clear && !start_stop && w_in_run;
  assign w_tick       = w_in_run && (r_presc == DIV_LAST);
  assign w_centi_wrap = (r_centi == C_LIM);
  assign w_sec_wrap   = (r_sec == S_LIM);
  assign w_min_wrap   = (r_min == M_LIM);

  // Next-state decode for the run/pause/idle sequencer
  always_comb begin
    w_state_next = r_state;
    if (w_clear_ok) begin
      w_state_next = ST_IDLE;
    end else if (w_toggle) begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_RUN;
        ST_RUN:   w_state_next = ST_PAUSE;
        ST_PAUSE: w_state_next = ST_RUN;
        default:  w_state_next = ST_IDLE;
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // State register and its registered RUN flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == ST_RUN);
    end
  end

  // Prescaler: advances only while running, holds its partial period across a pause
  always_ff @(posedge clk) begin
    if (rst || w_clear_ok) begin
      r_presc <= {PW{1'b0}};
    end else if (w_in_run) begin
      r_presc <= w_tick ? {PW{1'b0}} : r_presc + PW'(1);
    end
  end

  // Time cascade and the wrap-to-zero pulse
  always_ff @(posedge clk) begin
    if (rst || w_clear_ok) begin
      r_centi    <= 7'd0;
      r_sec      <= 6'd0;
      r_min      <= 6'd0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_tick && w_centi_wrap && w_sec_wrap && w_min_wrap;
      if (w_tick) begin
        r_centi <= wrap_inc7(r_centi, C_LIM);
        if (w_centi_wrap) begin
          r_sec <= wrap_inc6(r_sec, S_LIM);
          if (w_sec_wrap) begin
            r_min <= wrap_inc6(r_min, M_LIM);
          end
        end
      end
    end
  end

  // Lap capture takes the pre-tick value of the displayed time
  always_ff @(posedge clk) begin
    if (rst || w_clear_ok) begin
      r_lap_valid <= 1'b0;
      r_lap_centi <= 7'd0;
      r_lap_sec   <= 6'd0;
      r_lap_min   <= 6'd0;
    end else if (w_lap_take) begin
      r_lap_valid <= 1'b1;
      r_lap_centi <= r_centi;
      r_lap_sec   <= r_sec;
      r_lap_min   <= r_min;
    end
  end

  assign running   = r_running;
  assign centi     = r_centi;
  assign sec       = r_sec;
  assign min       = r_min;
  assign overflow  = r_overflow;
  assign lap_valid = r_lap_valid;
  assign lap_centi = r_lap_centi;
  assign lap_sec   = r_lap_sec;
  assign lap_min   = r_lap_min;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table, directed corner sequences and random pulses,
// all cross-checked against a total-elapsed-ticks reference model.
module tb_stopwatch_ctrl;

  localparam int CLK_DIV = 4;
  localparam int CL      = 99;
  localparam int SL      = 5;
  localparam int ML      = 2;
  localparam int PERIOD  = (CL + 1) * (SL + 1) * (ML + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic       running;
  logic [6:0] centi;
  logic [5:0] sec;
  logic [5:0] min;
  logic       lap_valid;
  logic [6:0] lap_centi;
  logic [5:0] lap_sec;
  logic [5:0] lap_min;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=idle 1=run 2=pause, elapsed ticks as one integer
  int m_mode  = 0;
  int m_phase = 0;
  int m_t     = 0;
  int m_lap_t = 0;
  bit m_lapv  = 1'b0;
  bit m_ovf   = 1'b0;

  stopwatch_ctrl #(
    .CLK_DIV(CLK_DIV), .CENTI_LIMIT(CL), .SEC_LIMIT(SL), .MIN_LIMIT(ML)
  ) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
    .running(running), .centi(centi), .sec(sec), .min(min),
    .lap_valid(lap_valid), .lap_centi(lap_centi), .lap_sec(lap_sec),
    .lap_min(lap_min), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [40:0] model_vec();
    int t_c, t_s, t_m, l_c, l_s, l_m;
    t_c = m_t % (CL + 1);
    t_s = (m_t / (CL + 1)) % (SL + 1);
    t_m = m_t / ((CL + 1) * (SL + 1));
    l_c = m_lap_t % (CL + 1);
    l_s = (m_lap_t / (CL + 1)) % (SL + 1);
    l_m = m_lap_t / ((CL + 1) * (SL + 1));
    return {(m_mode == 1), 7'(t_c), 6'(t_s), 6'(t_m),
            m_lapv, 7'(l_c), 6'(l_s), 6'(l_m), m_ovf};
  endfunction

  task automatic model_step(input bit r, input bit s, input bit l, input bit c);
    bit tick;
    if (r) begin
      m_mode = 0; m_phase = 0; m_t = 0; m_lap_t = 0; m_lapv = 1'b0; m_ovf = 1'b0;
    end else begin
      tick  = (m_mode == 1) && (m_phase == CLK_DIV - 1);
      m_ovf = 1'b0;
      if (c && m_mode != 1) begin
        m_mode = 0; m_phase = 0; m_t = 0; m_lap_t = 0; m_lapv = 1'b0;
      end else begin
        if (l && !c && !s && m_mode == 1) begin
          m_lap_t = m_t;
          m_lapv  = 1'b1;
        end
        if (m_mode == 1) begin
          m_phase = tick ? 0 : m_phase + 1;
          if (tick) begin
            m_t = m_t + 1;
            if (m_t == PERIOD) begin
              m_t   = 0;
              m_ovf = 1'b1;
            end
          end
        end
        if (s && !c) m_mode = (m_mode == 1) ? 2 : 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit l, input bit c);
    @(negedge clk);
    rst = r; start_stop = s; lap = l; clear = c;
    @(posedge clk);
    model_step(r, s, l, c);
    #1;
    chk("model", 64'({running, centi, sec, min, lap_valid, lap_centi, lap_sec,
                      lap_min, overflow}), 64'(model_vec()));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit r, s, l, c;
    int extra;
    bit run;
    int centi;
    int sec;
    int min;
    bit lapv;
    int lapc;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // r s l c extra | run centi sec min lapv lapc
    tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 2,  1, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 3,  1, 2, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0,  1, 2, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 0, 1, 0,  1, 2, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 0,  0, 2, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 19, 0, 2, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 0,  0, 2, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 0, 0,  1, 2, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0,  1, 3, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 1, 0, 0,  1, 3, 0, 0, 1, 3};
    tbl[15] = '{0, 1, 0, 0, 0,  0, 3, 0, 0, 1, 3};
    tbl[16] = '{0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].c);
      idle(tbl[i].extra);
      chk($sformatf("tbl%0d_running", i),   64'(running),   64'(tbl[i].run));
      chk($sformatf("tbl%0d_centi", i),     64'(centi),     64'(tbl[i].centi));
      chk($sformatf("tbl%0d_sec", i),       64'(sec),       64'(tbl[i].sec));
      chk($sformatf("tbl%0d_min", i),       64'(min),       64'(tbl[i].min));
      chk($sformatf("tbl%0d_lap_valid", i), 64'(lap_valid), 64'(tbl[i].lapv));
      chk($sformatf("tbl%0d_lap_centi", i), 64'(lap_centi), 64'(tbl[i].lapc));
      chk($sformatf("tbl%0d_overflow", i),  64'(overflow),  64'(0));
    end

    // centi 99 -> sec carry
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(396);
    chk("c99_centi", 64'(centi), 64'(99));
    chk("c99_sec",   64'(sec),   64'(0));
    idle(4);
    chk("carry_centi", 64'(centi), 64'(0));
    chk("carry_sec",   64'(sec),   64'(1));
    chk("carry_min",   64'(min),   64'(0));

    // run to the maximum time, then wrap
    idle(6796);
    chk("max_centi", 64'(centi), 64'(CL));
    chk("max_sec",   64'(sec),   64'(SL));
    chk("max_min",   64'(min),   64'(ML));
    idle(3);
    chk("pre_wrap_ovf", 64'(overflow), 64'(0));
    idle(1);
    chk("wrap_time", 64'({centi, sec, min}), 64'(0));
    chk("wrap_ovf",  64'(overflow), 64'(1));
    chk("wrap_run",  64'(running),  64'(1));
    idle(1);
    chk("ovf_one_cycle", 64'(overflow), 64'(0));
    chk("post_wrap_run", 64'(running),  64'(1));

    // pause with the prescaler frozen at 2, resume continues the partial period
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pause_run", 64'(running), 64'(0));
    idle(20);
    chk("pause_hold_centi", 64'(centi), 64'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("resume_run", 64'(running), 64'(1));
    idle(1);
    chk("resume_1_centi", 64'(centi), 64'(0));
    idle(1);
    chk("resume_2_centi", 64'(centi), 64'(1));

    // lap coinciding with a tick at 00:03.41
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1367);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lap_valid", 64'(lap_valid), 64'(1));
    chk("lap_time",  64'({lap_min, lap_sec, lap_centi}), 64'({6'd0, 6'd3, 7'd41}));
    chk("disp_time", 64'({min, sec, centi}), 64'({6'd0, 6'd3, 7'd42}));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lap_pause_time", 64'({lap_min, lap_sec, lap_centi}), 64'({6'd0, 6'd3, 7'd41}));

    // clear + start_stop in PAUSE, then reset mid-run
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_ss_run",  64'(running), 64'(0));
    chk("clr_ss_time", 64'({min, sec, centi}), 64'(0));
    chk("clr_ss_lapv", 64'(lap_valid), 64'(0));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("prerst_centi", 64'(centi), 64'(2));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_all", 64'({running, centi, sec, min, lap_valid, lap_centi, lap_sec,
                        lap_min, overflow}), 64'(0));
    idle(5);
    chk("rst_stays_idle", 64'({running, centi}), 64'(0));

    // random pulse traffic against the model
    for (int i = 0; i < 20000; i++) begin
      bit r, s, l, c;
      r = ($urandom_range(2999, 0) == 0);
      s = ($urandom_range(149, 0) == 0);
      l = ($urandom_range(19, 0) == 0);
      c = ($urandom_range(99, 0) == 0);
      step(r, s, l, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control/sequencing block for the timer datapath: run/pause/clear state machine gating a clock prescaler and a cascade of wrap-around counters (centiseconds, seconds, minutes).
- Sits between debounced single-cycle button pulses and the display/segment drivers.
- Also provides a lap-capture register and an overflow pulse.

Parameters:
- CLK_DIV, 100, clk cycles per centisecond tick; legal range >= 2.
- CENTI_LIMIT, 99, last centisecond value before wrapping to 0.
- SEC_LIMIT, 59, last second value before wrapping to 0.
- MIN_LIMIT, 59, last minute value before wrapping to 0.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start_stop  input  1  single-cycle pulse; toggles run/pause.
- lap  input  1  single-cycle pulse; captures the current time while running.
- clear  input  1  single-cycle pulse; zeroes the time when not running.
- running  output  1  high while in RUN.
- centi  output  7  centiseconds, 0..CENTI_LIMIT.
- sec  output  6  seconds, 0..SEC_LIMIT.
- min  output  6  minutes, 0..MIN_LIMIT.
- lap_valid  output  1  high once a lap has been captured; cleared by clear or rst.
- lap_centi  output  7  captured centiseconds.
- lap_sec  output  6  captured seconds.
- lap_min  output  6  captured minutes.
- overflow  output  1  one-cycle pulse when the count wraps from max to 0:00.00.

Behaviour:
- Reset:
  - rst high at an edge forces state IDLE and zeroes the prescaler, centi, sec, min, all lap_* registers, lap_valid, running and overflow.
  - rst overrides all other inputs, including mid-run.
- States: IDLE (time zero, never started), RUN, PAUSE.
- running is registered: it equals (state == RUN).
- Input priority in one cycle: clear > start_stop > lap. Lower-priority pulses in the same cycle are dropped.
- Transitions on start_stop:
  - IDLE -> RUN.
  - RUN -> PAUSE.
  - PAUSE -> RUN.
- clear:
  - In PAUSE or IDLE: go to IDLE, zero the prescaler, centi, sec, min, lap_* registers and lap_valid.
  - In RUN: ignored entirely. Any start_stop or lap pulse in that same cycle is still dropped per the priority rule.
- Prescaler:
  - Counts 0..CLK_DIV-1 only in cycles where state == RUN.
  - tick = (state == RUN) && (prescaler == CLK_DIV-1); the prescaler returns to 0 on tick.
  - Frozen (value held) in PAUSE, so a resume continues the partial period.
- Cascade, updated at the edge where tick = 1:
  - centi increments, or wraps to 0 at CENTI_LIMIT.
  - On a centi wrap, sec increments, or wraps at SEC_LIMIT.
  - On a sec wrap, min increments, or wraps at MIN_LIMIT.
- Overflow: when centi, sec and min are all at their limits during a tick, all three become 0, overflow = 1 for exactly one cycle, and the state stays RUN.
- Latency:
  - start_stop sampled at edge N (from IDLE): running = 1 after edge N.
  - centi becomes 1 after edge N+CLK_DIV.
  - Pause at edge M: no count change after edge M.
- Lap:
  - Honoured only in RUN.
  - Copies the current outputs into lap_* at that edge and sets lap_valid = 1.
  - If tick occurs in the same cycle, lap_* receive the pre-increment value.
  - Lap in IDLE/PAUSE is ignored.
  - A later lap overwrites the previous capture.
- start_stop and tick in the same cycle (RUN -> PAUSE): the tick increment still takes effect, and the prescaler goes to 0.
- Counter widths are fixed as listed. Parameter limits must fit those widths; exceeding them is illegal configuration and is not checked.

Test Plan (CLK_DIV = 4):
- rst for 2 cycles, then start_stop pulse at edge N -> running = 1 after N; centi = 1 after edge N+4; centi = 2 after N+8.
- Run until centi = 99, sec = 0, then one more tick -> centi = 0, sec = 1, min unchanged.
- Preload via run to 59:59.99, one more tick -> all zero, overflow high exactly one cycle, running stays 1.
- Pause with prescaler = 2, wait 20 cycles (no change), resume -> next centi increment 2 RUN cycles after resume. clear during RUN -> ignored. clear during PAUSE -> IDLE, all zero, lap_valid = 0.
- lap coinciding with tick at time 00:03.41 -> lap = 00:03.41, display = 00:03.42, lap_valid = 1. lap during PAUSE -> lap_* unchanged.
- clear + start_stop together in PAUSE -> IDLE, zeroed, not running. rst asserted mid-RUN -> all outputs 0 next cycle, state IDLE.
